se_sram_srw_req_ctl: RTL and testbench
======================================

Name: se_sram_srw_req_ctl

Overview:
- Request front-end that sits directly upstream of a single-port se_sram_srw/se_sram_srw_we instance and drives its select, read_not_write, address and write_data pins.
- Converts a valid/ready request stream into SRAM accesses and captures the registered SRAM read data into a 2-entry response buffer with valid/ready back-pressure.
- Sustains one access per cycle while rsp_ready is held high.

Parameters:
address_width, 14, SRAM address width; must match the attached SRAM
data_width, 32, SRAM data width; must match the attached SRAM

Ports:
sram_clock  input  1  clock shared with the SRAM; the SRAM's sram_clock__enable is tied high at integration
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted this cycle when req_valid && req_ready
req_read_not_write  input  1  1=read, 0=write
req_address  input  address_width  request address
req_write_data  input  data_width  write data
rsp_valid  output  1  read response available
rsp_ready  input  1  consumer takes response this cycle
rsp_data  output  data_width  read response data (head of buffer)
busy  output  1  clear in progress, read in flight, or buffer non-empty
sram_select  output  1  to SRAM select
sram_read_not_write  output  1  to SRAM read_not_write
sram_address  output  address_width  to SRAM address
sram_write_data  output  data_width  to SRAM write_data
sram_data_out  input  data_width  from SRAM data_out (registered in the SRAM, valid the cycle after a read select)

Behaviour:
- Clock and reset: one clock, sram_clock. Reset is synchronous and active-high.
- Reset values: rsp_valid=0, rsp_data=0, busy=0 (or 1 while clearing, see Optional Feature), read-in-flight flag=0, buffer occupancy=0, write/read pointers=0.
- Reset asserted mid-operation discards any in-flight read and all buffered responses. No response is produced for them.
- Accept: accept = req_valid && req_ready && !clearing.
- SRAM drive, combinational from the request inputs:
  - sram_select = accept (or clear drive).
  - sram_read_not_write = req_read_not_write.
  - sram_address = req_address.
  - sram_write_data = req_write_data.
  - When not selected, the SRAM outputs are don't-care.
- Space accounting: pop = rsp_valid && rsp_ready. space = (occupancy + inflight - pop) < 2.
- req_ready = !clearing && (!req_read_not_write || space).
  - Writes are never blocked by the response buffer.
  - req_ready combinationally depends on req_read_not_write; this is permitted.
- Read latency: a read accepted in cycle N sets inflight for cycle N+1. In cycle N+1, sram_data_out is pushed into the buffer. rsp_valid is first high in cycle N+2 with that data. Fixed latency is 2 cycles.
- Writes accepted in cycle N are committed by the SRAM at the end of N and produce no response.
- A read accepted at N+1 to the same address returns the new data.
- The buffer is a 2-entry FIFO returning responses in request order.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Overflow is impossible by construction; the bench asserts it never occurs.
- rsp_data and rsp_valid must hold stable while rsp_valid && !rsp_ready.
- busy = clearing || inflight || occupancy != 0.

Optional Feature:
- Macro: SE_SRAM_REQ_CTL_CLEAR_EN.
- When defined, reset enters a CLEAR state with an address_width-bit counter at 0. Each cycle in CLEAR:
  - sram_select=1, sram_read_not_write=0, sram_address=counter, sram_write_data=0.
  - The counter increments; it leaves CLEAR after writing address 2^address_width-1.
  - In CLEAR, req_ready=0 and busy=1.
  - The first cycle with req_ready possible is 2^address_width cycles after reset deasserts.
- Reset during CLEAR restarts the clear from address 0.
- When not defined, the clearing signal is constant 0, and req_ready may be 1 in the first cycle after reset.

Test Plan:
- Reset then idle -> rsp_valid=0, busy=0 (macro off); all SRAM contents zero after 2^address_width cycles (macro on, address_width=4: req_ready rises at cycle 16).
- Write 0xDEADBEEF@0x10, next cycle read 0x10, rsp_ready=1 -> sram_select high both cycles; rsp_valid only in read cycle+2 with rsp_data=0xDEADBEEF.
- 8 back-to-back reads of addresses 0..7 preloaded with values 0x100+addr, rsp_ready=1 -> req_ready constant 1; 8 responses on consecutive cycles in order 0x100..0x107.
- Reads streaming with rsp_ready=0 -> exactly 2 reads accepted, then req_ready=0 for reads while writes are still accepted; raising rsp_ready drains in order and read acceptance resumes the same cycle as the pop.
- Random rsp_ready toggling during 1000 mixed requests against a reference model -> data matches, order is preserved, no buffer overflow, rsp_data stable while stalled.
- Reset asserted one cycle after a read is accepted with the buffer holding 1 entry -> rsp_valid=0 the next cycle, and no stale response appears afterwards.

Source files
------------

// File: rtl/se_sram_srw_req_ctl.sv
// -----------------------------------------------------------------------------
// se_sram_srw_req_ctl
//
// Request front-end for a single-port se_sram_srw / se_sram_srw_we instance.
// Turns a valid/ready request stream into SRAM accesses (one per cycle) and
// captures the registered SRAM read data into a 2-entry response FIFO with
// valid/ready back-pressure. Reads have a fixed 2-cycle latency from accept
// to rsp_valid; writes produce no response.
//
// Optional feature macro: SE_SRAM_REQ_CTL_CLEAR_EN
//   When defined, reset starts a clear sweep that writes zero to every SRAM
//   address (one per cycle) before any request can be accepted.
//
// Ports:
//   sram_clock           clock shared with the SRAM
//   reset                synchronous, active-high reset
//   req_valid/req_ready  request handshake
//   req_read_not_write   1=read, 0=write
//   req_address          request address
//   req_write_data       write data
//   rsp_valid/rsp_ready  read response handshake
//   rsp_data             read response data (head of buffer)
//   busy                 clear in progress, read in flight, or buffer non-empty
//   sram_select          to SRAM select
//   sram_read_not_write  to SRAM read_not_write
//   sram_address         to SRAM address
//   sram_write_data      to SRAM write_data
//   sram_data_out        from SRAM data_out (valid the cycle after a read)
// -----------------------------------------------------------------------------
module se_sram_srw_req_ctl #(
    parameter int address_width = 14,
    parameter int data_width    = 32
) (
    input  logic                     sram_clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_read_not_write,
    input  logic [address_width-1:0] req_address,
    input  logic [data_width-1:0]    req_write_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [data_width-1:0]    rsp_data,
    output logic                     busy,
    output logic                     sram_select,
    output logic                     sram_read_not_write,
    output logic [address_width-1:0] sram_address,
    output logic [data_width-1:0]    sram_write_data,
    input  logic [data_width-1:0]    sram_data_out
);

    // ------------------------------------------------------------------
    // Clear sweep (optional)
    // ------------------------------------------------------------------
    logic                     clearing;
    logic [address_width-1:0] clear_addr;

`ifdef SE_SRAM_REQ_CTL_CLEAR_EN
    logic                     clear_active_q, clear_active_d;
    logic [address_width-1:0] clear_addr_q, clear_addr_d;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        clear_active_d = clear_active_q;
        clear_addr_d   = clear_addr_q;
        if (clear_active_q) begin
            clear_addr_d = clear_addr_q + address_width'(1);
            // Leave after the cycle that writes the last address.
            if (&clear_addr_q) begin
                clear_active_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge sram_clock) begin
        if (reset) begin
            clear_active_q <= 1'b1;
            clear_addr_q   <= '0;
        end else begin
            clear_active_q <= clear_active_d;
            clear_addr_q   <= clear_addr_d;
        end
    end

    assign clearing   = clear_active_q;
    assign clear_addr = clear_addr_q;
`else
    assign clearing   = 1'b0;
    assign clear_addr = '0;
`endif

    // ------------------------------------------------------------------
    // Request acceptance and SRAM drive
    // ------------------------------------------------------------------
    logic            inflight_q, inflight_d;
    logic [1:0]      count_q, count_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [data_width-1:0] buf_q [2];
    logic [data_width-1:0] buf_d [2];

    logic       pop;
    logic       push;
    logic       accept;
    logic       space;
    logic [2:0] pending;

    assign rsp_valid = (count_q != 2'd0);
    assign rsp_data  = buf_q[rd_ptr_q];
    assign pop       = rsp_valid && rsp_ready;
    assign push      = inflight_q;

    // Entries already committed to the buffer (stored or in flight) after
    // this cycle's pop; a new read needs that to leave room for one more.
    assign pending = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign space   = (pending < 3'd2);

    assign req_ready = !clearing && (!req_read_not_write || space);
    assign accept    = req_valid && req_ready && !clearing;

    assign sram_select         = accept || clearing;
    assign sram_read_not_write = clearing ? 1'b0 : req_read_not_write;
    assign sram_address        = clearing ? clear_addr : req_address;
    assign sram_write_data     = clearing ? '0 : req_write_data;

    assign busy = clearing || inflight_q || (count_q != 2'd0);

    // ------------------------------------------------------------------
    // Response buffer: 2-entry FIFO fed by the SRAM's registered data_out
    // ------------------------------------------------------------------
    always_comb begin
        inflight_d = accept && req_read_not_write;
        count_d    = count_q + 2'(push) - 2'(pop);
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        buf_d      = buf_q;
        if (push) begin
            buf_d[wr_ptr_q] = sram_data_out;
        end
    end

    always_ff @(posedge sram_clock) begin
        if (reset) begin
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            // NOTE: the buffer storage is reset too, so rsp_data reads as
            // zero after reset instead of leftover data from before it.
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: tb/tb_se_sram_srw_req_ctl.sv
// -----------------------------------------------------------------------------
// tb_se_sram_srw_req_ctl
//
// Bench for se_sram_srw_req_ctl. A behavioural SRAM drives sram_data_out; a
// reference model (expected memory image plus a queue of expected read
// responses tagged with their due cycle) predicts every output each cycle.
// Directed sequences add literal expectations on top of the model.
// -----------------------------------------------------------------------------
module tb_se_sram_srw_req_ctl;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NWORDS = 1 << AW;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_read_not_write;
    logic [AW-1:0] req_address;
    logic [DW-1:0] req_write_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          busy;
    logic          sram_select;
    logic          sram_read_not_write;
    logic [AW-1:0] sram_address;
    logic [DW-1:0] sram_write_data;
    logic [DW-1:0] sram_data_out;

    se_sram_srw_req_ctl #(
        .address_width(AW),
        .data_width   (DW)
    ) dut (
        .sram_clock         (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_read_not_write (req_read_not_write),
        .req_address        (req_address),
        .req_write_data     (req_write_data),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_data           (rsp_data),
        .busy               (busy),
        .sram_select        (sram_select),
        .sram_read_not_write(sram_read_not_write),
        .sram_address       (sram_address),
        .sram_write_data    (sram_write_data),
        .sram_data_out      (sram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural SRAM: registered read data, unwritten words hold a
    // deterministic per-address pattern.
    // ------------------------------------------------------------------
    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 32'h9E3779B1) ^ 32'h00005A5A;
    endfunction

    logic [DW-1:0] sram_mem     [NWORDS];
    logic          sram_written [NWORDS];

    always @(posedge clk) begin
        if (sram_select) begin
            if (sram_read_not_write) begin
                sram_data_out <= sram_written[sram_address] ? sram_mem[sram_address]
                                                             : init_val(int'(sram_address));
            end else begin
                sram_mem[sram_address]     <= sram_write_data;
                sram_written[sram_address] <= 1'b1;
            end
        end
    end

    initial begin
        sram_data_out = '0;
        for (int i = 0; i < NWORDS; i++) sram_written[i] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q [$];
    logic [DW-1:0] model_mem [NWORDS];
    int            cyc;

    int n_checks;
    int n_fail;

    logic          last_valid;
    logic [DW-1:0] last_data;
    logic          last_rdy;
    logic          last_sel;
    logic          stall_prev;
    logic [DW-1:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare every output against the model
    // at the falling edge, then advance the model at the rising edge.
    task automatic cycle(input logic v, input logic rnw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic rr);
        logic          exp_valid;
        logic          exp_rdy;
        logic          pop;
        logic          acc;
        logic [DW-1:0] exp_data;
        int            pend;

        req_valid          = v;
        req_read_not_write = rnw;
        req_address        = a;
        req_write_data     = d;
        rsp_ready          = rr;
        @(negedge clk);

        exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        exp_data  = exp_valid ? exp_q[0].data : '0;
        pop       = exp_valid && rr;
        pend      = exp_q.size() - (pop ? 1 : 0);
        exp_rdy   = !rnw || (pend < 2);
        acc       = v && exp_rdy;

        check("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
        if (exp_valid) check("rsp_data", 64'(rsp_data), 64'(exp_data));
        if (stall_prev) check("rsp_data_stable", 64'(rsp_data), 64'(prev_data));
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("busy", 64'(busy), 64'(exp_q.size() != 0));
        check("sram_select", 64'(sram_select), 64'(acc));
        if (acc) begin
            check("sram_address", 64'(sram_address), 64'(a));
            check("sram_read_not_write", 64'(sram_read_not_write), 64'(rnw));
            if (!rnw) check("sram_write_data", 64'(sram_write_data), 64'(d));
        end
        if (v && rnw && req_ready) check("no_overflow", 64'(pend < 2), 64'(1));

        last_valid = rsp_valid;
        last_data  = rsp_data;
        last_rdy   = req_ready;
        last_sel   = sram_select;
        stall_prev = rsp_valid && !rr;
        prev_data  = rsp_data;

        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            if (rnw) exp_q.push_back('{due: cyc + 2, data: model_mem[a]});
            else     model_mem[a] = d;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic do_reset();
        req_valid          = 1'b0;
        req_read_not_write = 1'b0;
        req_address        = '0;
        req_write_data     = '0;
        rsp_ready          = 1'b0;
        reset              = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        reset = 1'b0;
        exp_q.delete();
        stall_prev = 1'b0;
`ifdef SE_SRAM_REQ_CTL_CLEAR_EN
        for (int i = 0; i < NWORDS; i++) model_mem[i] = '0;
        for (int i = 0; i < NWORDS; i++) begin
            @(negedge clk);
            check("clear_req_ready", 64'(req_ready), 64'(0));
            check("clear_busy", 64'(busy), 64'(1));
            @(posedge clk);
            #1;
            cyc++;
        end
`endif
        @(negedge clk);
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_data", 64'(rsp_data), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_req_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int accepted;
        logic v, rnw, rr;

        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        stall_prev = 1'b0;
        last_valid = 1'b0;
        last_data  = '0;
        last_rdy   = 1'b0;
        last_sel   = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < NWORDS; i++) model_mem[i] = init_val(i);

        do_reset();
        idle(3);

        // Write then read the same address on the next cycle.
        cycle(1'b1, 1'b0, 6'h10, 32'hDEADBEEF, 1'b1);
        check("wr_select", 64'(last_sel), 64'(1));
        cycle(1'b1, 1'b1, 6'h10, '0, 1'b1);
        check("rd_select", 64'(last_sel), 64'(1));
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        check("rd_plus1_valid", 64'(last_valid), 64'(0));
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        check("rd_plus2_valid", 64'(last_valid), 64'(1));
        check("rd_plus2_data", 64'(last_data), 64'h0000_0000_DEAD_BEEF);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        check("rd_plus3_valid", 64'(last_valid), 64'(0));

        // Preload 0..7, then 8 back-to-back reads.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, AW'(i), DW'(32'h100 + i), 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(i < 8, 1'b1, AW'(i), '0, 1'b1);
            if (i < 8) check("b2b_req_ready", 64'(last_rdy), 64'(1));
            if (i >= 2) begin
                check("b2b_valid", 64'(last_valid), 64'(1));
                check("b2b_data", 64'(last_data), 64'(32'h100 + i - 2));
            end
        end
        idle(2);

        // Stalled consumer: only two reads fit, writes still go through.
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, AW'(i), '0, 1'b0);
            if (last_rdy) accepted++;
        end
        check("stall_reads_accepted", 64'(accepted), 64'(2));
        cycle(1'b1, 1'b0, 6'h20, 32'h0BAD_F00D, 1'b0);
        check("stall_write_ready", 64'(last_rdy), 64'(1));
        cycle(1'b1, 1'b1, 6'h20, '0, 1'b1);
        check("resume_on_pop", 64'(last_rdy), 64'(1));
        check("resume_head", 64'(last_data), 64'(32'h100));
        idle(5);

        // Randomized mixed traffic with random back-pressure.
        for (int i = 0; i < 1000; i++) begin
            v   = ($urandom_range(3) != 0);
            rnw = $urandom_range(1) == 1;
            rr  = ($urandom_range(2) != 0);
            cycle(v, rnw, AW'($urandom_range(15)), DW'($urandom), rr);
        end
        idle(5);

        // Reset with one buffered response and one read in flight.
        cycle(1'b1, 1'b1, 6'h01, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b1, 6'h02, '0, 1'b0);
        check("pre_reset_valid", 64'(last_valid), 64'(1));
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b1);
            check("no_stale_rsp", 64'(last_valid), 64'(0));
        end
        cycle(1'b1, 1'b1, 6'h01, '0, 1'b1);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
